mopshub_rec_bus_arbiter: RTL

- Round-robin scheduler that shares the single MOPSHUB uplink receive path (CAN-receive to e-link) among up to 16 CAN bus controllers.
- Collects per-bus "frame received" requests and drives can_rec_select.
- Launches one uplink transfer at a time and waits for its completion handshake. Times out a stuck transfer so no bus can starve the others.
- Sits between the 16 bus controllers and the uplink packer in mopshub_top_16bus.

---
 rtl/mopshub_rec_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mopshub_rec_bus_arbiter.sv
// Round-robin owner of the MOPSHUB uplink receive path across up to 16 CAN bus controllers.
// Latency: request sampled in IDLE -> ARB next cycle -> rec_start the cycle after; ack follows the cycle after rec_done.
// Backpressure: one transfer in flight; later requests stay pending until ack, and a stuck transfer is aborted after TIMEOUT cycles.
module mopshub_rec_bus_arbiter #(
    parameter int N_BUS   = 16,
    parameter int SEL_W   = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_40_m,
    input  logic             rst,
    input  logic [SEL_W-1:0] n_buses,
    input  logic [N_BUS-1:0] bus_req,
    output logic [N_BUS-1:0] bus_ack,
    output logic [SEL_W-1:0] can_rec_select,
    output logic             rec_start,
    input  logic             rec_done,
    output logic             rec_busy,
    output logic             timeout_err,
    output logic [15:0]      grant_cnt
);

    localparam int CNT_W = 10;
    localparam int IDX_W = $clog2(N_BUS);
    localparam logic [SEL_W-1:0] MAX_IDX   = SEL_W'(N_BUS - 1);
    localparam logic [SEL_W-1:0] NONE      = '1;
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        GRANT,
        WAIT_DONE,
        ACK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] max_idx;
    logic [SEL_W-1:0] start_idx;
    logic [SEL_W-1:0] srch_idx;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_vld;
    logic [N_BUS-1:0] elig;
    logic [CNT_W-1:0] to_cnt;

    always_comb begin
        max_idx = (n_buses > MAX_IDX) ? MAX_IDX : n_buses;
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_BUS; i++) begin
            elig[i] = bus_req[i] && (SEL_W'(i) <= max_idx);
        end
    end

    // Circular search over 0..max_idx beginning just after the previous owner.
    // NONE (all ones) is always >= max_idx, so a fresh arbiter starts at bus 0.
    always_comb begin
        start_idx = (last_grant >= max_idx) ? '0 : last_grant + SEL_W'(1);
        srch_idx  = '0;
        pick_vld  = 1'b0;
        pick_idx  = '0;
        for (int i = 0; i < N_BUS; i++) begin
            srch_idx = start_idx + SEL_W'(i);
            if (srch_idx > max_idx) begin
                srch_idx = srch_idx - max_idx - SEL_W'(1);
            end
            if (!pick_vld && (SEL_W'(i) <= max_idx) && elig[srch_idx[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = srch_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rec_start   = 1'b0;
        rec_busy    = 1'b0;
        timeout_err = 1'b0;
        bus_ack     = '0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                state_nxt = pick_vld ? GRANT : IDLE;
            end
            GRANT: begin
                rec_start = 1'b1;
                rec_busy  = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                rec_busy = 1'b1;
                // A completion arriving on the timeout cycle wins over the abort.
                if (rec_done) begin
                    state_nxt = ACK;
                end else if (to_cnt == TO_LIMIT) begin
                    timeout_err = 1'b1;
                    state_nxt   = ACK;
                end
            end
            ACK: begin
                rec_busy = 1'b1;
                bus_ack[can_rec_select[IDX_W-1:0]] = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            can_rec_select <= '0;
            last_grant     <= NONE;
            to_cnt         <= '0;
            grant_cnt      <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (pick_vld) begin
                        can_rec_select <= pick_idx;
                    end
                end
                GRANT: begin
                    to_cnt <= '0;
                end
                WAIT_DONE: begin
                    if (to_cnt != TO_LIMIT) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    last_grant <= can_rec_select;
                    grant_cnt  <= grant_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
